pixel_writer: RTL

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer_pkg.sv | 20 ++
 rtl/pixel_writer_fifo.sv | 64 ++++++
 rtl/pixel_writer.sv | 119 +++++++++++
 3 files changed

// File: rtl/pixel_writer_pkg.sv
// ---------------------------------------------------------------------------
// | pixel_writer_pkg : shared coordinate width and FSM state encodings      |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package pixel_writer_pkg;

   localparam int COORD_W = 32;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/pixel_writer_fifo.sv
// ---------------------------------------------------------------------------
// | pixel_fifo : register-based address FIFO with full/empty flags          |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module pixel_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 12
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0]    wr_q, wr_d, rd_q, rd_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              do_push, do_pop;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                    (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
   assign empty_o = (wr_q == rd_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_q[PTR_W-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (clr_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + (PTR_W+1)'(1);
         if (do_pop)  rd_d = rd_q + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !clr_i) mem_q[wr_q[PTR_W-1:0]] <= wdata_i;
   end

endmodule

`default_nettype wire

// File: rtl/pixel_writer.sv
// ---------------------------------------------------------------------------
// | pixel_writer : buffers coordinate pairs and writes COLOR to a frame     |
// | buffer. Define PIXEL_WRITER_CLIP_EN to discard off-screen pairs.        |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module pixel_writer
   import pixel_writer_pkg::*;
#(
   parameter int         WIDTH  = 64,
   parameter int         HEIGHT = 64,
   parameter int         DEPTH  = 4,
   parameter logic [7:0] COLOR  = 8'hFF,
   localparam int        ADDR_W = $clog2(WIDTH*HEIGHT)
) (
   input  logic                      _clock,
   input  logic                      _reset,
   input  logic                      _start,
   input  logic signed [COORD_W-1:0] _in0,
   input  logic signed [COORD_W-1:0] _in1,
   input  logic                      _in_valid,
   input  logic                      _in_done,
   output logic                      _ready,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [7:0]                mem_wdata,
   input  logic                      mem_ready,
   output logic [15:0]               pix_count,
   output logic [15:0]               clip_count,
   output logic                      _done
);

   localparam logic signed [COORD_W-1:0] C_WIDTH_S = COORD_W'(WIDTH);

   state_t            state_q, state_d;
   logic [15:0]       pix_q, pix_d, clip_q, clip_d;
   logic              fifo_full, fifo_empty, fifo_clr;
   logic              accept, push, pop, clip;
   logic [ADDR_W-1:0] lin_addr;

   assign fifo_clr = (state_q == ST_IDLE) && _start;
   assign _ready   = (state_q == ST_RUN) && !fifo_full;
   assign accept   = _in_valid && _ready;
   assign lin_addr = ADDR_W'(_in1 * C_WIDTH_S + _in0);

`ifdef PIXEL_WRITER_CLIP_EN
   localparam logic signed [COORD_W-1:0] C_HEIGHT_S = COORD_W'(HEIGHT);
   logic in_range;
   assign in_range = (_in0 >= 0) && (_in0 < C_WIDTH_S) &&
                     (_in1 >= 0) && (_in1 < C_HEIGHT_S);
   assign push     = accept && in_range;
   assign clip     = accept && !in_range;
`else
   assign push     = accept;
   assign clip     = 1'b0;
`endif

   assign mem_we     = !fifo_empty;
   assign pop        = mem_we && mem_ready;
   assign mem_wdata  = mem_we ? COLOR : 8'h00;
   assign pix_count  = pix_q;
   assign clip_count = clip_q;
   assign _done      = (state_q == ST_DONE);

   pixel_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (ADDR_W)
   ) u_fifo (
      .clk_i   (_clock),
      .rst_i   (_reset),
      .clr_i   (fifo_clr),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (lin_addr),
      .rdata_o (mem_addr),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (_start)     state_d = ST_RUN;
         ST_RUN:   if (_in_done)   state_d = ST_FLUSH;
         ST_FLUSH: if (fifo_empty) state_d = ST_DONE;
         ST_DONE:                  state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // Counters hold after the frame ends and clear only on the next start.
   always_comb begin
      pix_d  = pix_q;
      clip_d = clip_q;
      if (fifo_clr) begin
         pix_d  = '0;
         clip_d = '0;
      end else begin
         if (pop)  pix_d  = pix_q + 16'd1;
         if (clip) clip_d = clip_q + 16'd1;
      end
   end

   always_ff @(posedge _clock) begin
      if (_reset) begin
         state_q <= ST_IDLE;
         pix_q   <= '0;
         clip_q  <= '0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         clip_q  <= clip_d;
      end
   end

endmodule

`default_nettype wire
